// File: rtl/jtag_host_driver.sv
// Bit-banging JTAG host: drives tck/tms/tdi/trst toward a TAP from sys_clk and captures tdo.
// Optional macro JTAG_HOST_TRST_EN: trst pulses low for the first 2 TCKs of every RESET sequence.
module jtag_host_driver #(
   parameter int CLK_DIV = 2,
   parameter int MAX_LEN = 32,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               sys_clk,
   input  logic               dbg_rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               rsp_valid,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               tck,
   output logic               tms,
   output logic               tdi,
   output logic               trst,
   input  logic               tdo
);

   localparam logic [1:0] OP_RESET    = 2'd0;
   localparam logic [1:0] OP_SHIFT_IR = 2'd1;
   localparam logic [1:0] OP_SHIFT_DR = 2'd2;
   localparam logic [1:0] OP_IDLE     = 2'd3;

   localparam logic [2:0] IDLE_WAIT = 3'd0;
   localparam logic [2:0] RESET_SEQ = 3'd1;
   localparam logic [2:0] PRE       = 3'd2;
   localparam logic [2:0] SHIFT     = 3'd3;
   localparam logic [2:0] POST      = 3'd4;
   localparam logic [2:0] DONE      = 3'd5;

   // Step counter must also cover the 6-TCK reset walk when MAX_LEN is tiny.
   localparam int STEP_W = (LEN_W > 3) ? LEN_W : 3;
   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

`ifdef JTAG_HOST_TRST_EN
   localparam bit TRST_EN = 1'b1;
`else
   localparam bit TRST_EN = 1'b0;
`endif

   logic [2:0]         state_reg;
   logic [STEP_W-1:0]  step_reg;
   logic [1:0]         op_reg;
   logic [LEN_W-1:0]   len_reg;
   logic [MAX_LEN-1:0] data_reg;
   logic [MAX_LEN-1:0] cap_reg;
   logic [DIV_W-1:0]   div_reg;
   logic               synced_reg;
   logic               ready_reg;
   logic               rsp_valid_reg;
   logic [MAX_LEN-1:0] rsp_data_reg;
   logic               tck_reg;
   logic               tms_reg;
   logic               tdi_reg;
   logic               trst_reg;

   logic [LEN_W-1:0]   len_clamped;
   logic [2:0]         acc_state;
   logic [2:0]         post_reset_state;
   logic [STEP_W-1:0]  seg_last;
   logic               seg_end;
   logic [2:0]         adv_state;
   logic [STEP_W-1:0]  adv_step;
   logic               adv_done;
   logic [MAX_LEN-1:0] cur_hit;
   logic [MAX_LEN-1:0] adv_hit;
   logic               shifting;
   logic               adv_shifting;

   // Where a command lands once the TAP is known to sit in Run-Test/Idle.
   function automatic logic [2:0] entry_state(input logic [1:0] op, input logic [LEN_W-1:0] len);
      if (op == OP_SHIFT_IR || op == OP_SHIFT_DR)
         entry_state = PRE;
      else if (op == OP_IDLE && len != '0)
         entry_state = SHIFT;
      else
         entry_state = DONE;
   endfunction

   function automatic logic pin_tms(input logic [2:0] st, input logic [STEP_W-1:0] step,
                                    input logic [1:0] op, input logic [LEN_W-1:0] len);
      case (st)
         RESET_SEQ: pin_tms = (step != STEP_W'(5));
         PRE:       pin_tms = (op == OP_SHIFT_IR) ? (step < STEP_W'(2)) : (step == '0);
         SHIFT:     pin_tms = (op != OP_IDLE) && (step == STEP_W'(len) - STEP_W'(1));
         POST:      pin_tms = (step == '0);
         default:   pin_tms = 1'b0;
      endcase
   endfunction

   always_comb begin
      len_clamped = cmd_len;
      if (cmd_op != OP_IDLE) begin
         if (cmd_len == '0)
            len_clamped = LEN_W'(1);
         else if (cmd_len > LEN_W'(MAX_LEN))
            len_clamped = LEN_W'(MAX_LEN);
      end
   end

   assign acc_state        = (!synced_reg || cmd_op == OP_RESET) ? RESET_SEQ
                                                                 : entry_state(cmd_op, len_clamped);
   assign post_reset_state = entry_state(op_reg, len_reg);

   always_comb begin
      case (state_reg)
         RESET_SEQ: seg_last = STEP_W'(5);
         PRE:       seg_last = (op_reg == OP_SHIFT_IR) ? STEP_W'(3) : STEP_W'(2);
         SHIFT:     seg_last = STEP_W'(len_reg) - STEP_W'(1);
         POST:      seg_last = STEP_W'(1);
         default:   seg_last = '0;
      endcase
   end

   assign seg_end = (step_reg == seg_last);

   always_comb begin
      adv_state = state_reg;
      adv_step  = step_reg + STEP_W'(1);
      adv_done  = 1'b0;
      if (seg_end) begin
         adv_step = '0;
         case (state_reg)
            RESET_SEQ: begin
               adv_state = post_reset_state;
               adv_done  = (post_reset_state == DONE);
            end
            PRE:   adv_state = SHIFT;
            SHIFT: begin
               adv_state = POST;
               adv_done  = (op_reg == OP_IDLE);
            end
            default: adv_done = 1'b1;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < MAX_LEN; gi = gi + 1) begin : g_hit
         assign cur_hit[gi] = (step_reg == STEP_W'(gi));
         assign adv_hit[gi] = (adv_step == STEP_W'(gi));
      end
   endgenerate

   assign shifting     = (state_reg == SHIFT) && (op_reg != OP_IDLE);
   assign adv_shifting = (adv_state == SHIFT) && (op_reg != OP_IDLE);

   always_ff @(posedge sys_clk or negedge dbg_rst) begin
      if (!dbg_rst) begin
         state_reg     <= IDLE_WAIT;
         step_reg      <= '0;
         op_reg        <= OP_RESET;
         len_reg       <= '0;
         data_reg      <= '0;
         cap_reg       <= '0;
         div_reg       <= '0;
         synced_reg    <= 1'b0;
         ready_reg     <= 1'b1;
         rsp_valid_reg <= 1'b0;
         rsp_data_reg  <= '0;
         tck_reg       <= 1'b0;
         tms_reg       <= 1'b1;
         tdi_reg       <= 1'b0;
         trst_reg      <= !TRST_EN;
      end else begin
         rsp_valid_reg <= 1'b0;
         case (state_reg)
            IDLE_WAIT: begin
               trst_reg <= 1'b1;
               if (cmd_valid && ready_reg) begin
                  ready_reg <= 1'b0;
                  op_reg    <= cmd_op;
                  len_reg   <= len_clamped;
                  data_reg  <= cmd_data;
                  cap_reg   <= '0;
                  state_reg <= acc_state;
                  step_reg  <= '0;
                  div_reg   <= '0;
                  // No entry state shifts data on its first TCK, so TDI starts at 0.
                  tms_reg   <= pin_tms(acc_state, '0, cmd_op, len_clamped);
                  tdi_reg   <= 1'b0;
                  trst_reg  <= !(TRST_EN && acc_state == RESET_SEQ);
               end
            end
            DONE: begin
               rsp_valid_reg <= 1'b1;
               rsp_data_reg  <= cap_reg;
               ready_reg     <= 1'b1;
               state_reg     <= IDLE_WAIT;
               tms_reg       <= 1'b0;
            end
            default: begin
               if (div_reg != DIV_LAST) begin
                  div_reg <= div_reg + DIV_W'(1);
               end else begin
                  div_reg <= '0;
                  if (!tck_reg) begin
                     tck_reg <= 1'b1;
                     if (shifting)
                        cap_reg <= cap_reg | (cur_hit & {MAX_LEN{tdo}});
                  end else begin
                     tck_reg <= 1'b0;
                     if (state_reg == RESET_SEQ && seg_end)
                        synced_reg <= 1'b1;
                     if (adv_done) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_data_reg  <= cap_reg;
                        ready_reg     <= 1'b1;
                        state_reg     <= IDLE_WAIT;
                        step_reg      <= '0;
                        tms_reg       <= 1'b0;
                        tdi_reg       <= 1'b0;
                        trst_reg      <= 1'b1;
                     end else begin
                        state_reg <= adv_state;
                        step_reg  <= adv_step;
                        tms_reg   <= pin_tms(adv_state, adv_step, op_reg, len_reg);
                        tdi_reg   <= adv_shifting && |(data_reg & adv_hit);
                        trst_reg  <= !(TRST_EN && adv_state == RESET_SEQ && adv_step < STEP_W'(2));
                     end
                  end
               end
            end
         endcase
      end
   end

   assign cmd_ready = ready_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_data  = rsp_data_reg;
   assign tck       = tck_reg;
   assign tms       = tms_reg;
   assign tdi       = tdi_reg;
   assign trst      = trst_reg;

endmodule

// File: tb/tb_jtag_host_driver.sv
// Scoreboard bench for jtag_host_driver: randomized commands against a TCK-sequence model.
module tb_jtag_host_driver;

   localparam int CLK_DIV = 2;
   localparam int MAX_LEN = 32;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);

`ifdef JTAG_HOST_TRST_EN
   localparam bit TRST_EN_TB = 1'b1;
`else
   localparam bit TRST_EN_TB = 1'b0;
`endif

   localparam logic [1:0] OP_RESET = 2'd0;
   localparam logic [1:0] OP_IR    = 2'd1;
   localparam logic [1:0] OP_DR    = 2'd2;
   localparam logic [1:0] OP_IDLE  = 2'd3;

   logic               sys_clk = 1'b0;
   logic               dbg_rst;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [LEN_W-1:0]   cmd_len;
   logic [MAX_LEN-1:0] cmd_data;
   logic               rsp_valid;
   logic [MAX_LEN-1:0] rsp_data;
   logic               tck, tms, tdi, trst;
   logic               tdo;

   jtag_host_driver #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
      .sys_clk(sys_clk), .dbg_rst(dbg_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_len(cmd_len), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .tck(tck), .tms(tms), .tdi(tdi), .trst(trst), .tdo(tdo)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] rsp;
      int          ntck;
      logic [63:0] tms_v;
      logic [63:0] tdi_v;
      longint      acc;
      int          lat;
      int          trst_low;
   } exp_t;

   exp_t   exp_q[$];
   int     tests = 0;
   int     fails = 0;
   longint cyc = 0;
   int     rise_cnt = 0;
   bit     pat[256];
   bit     model_synced = 1'b0;

   initial forever #5 sys_clk = ~sys_clk;
   initial forever begin @(posedge sys_clk); cyc++; end

   // Target TAP stand-in: TDO for the r-th rising TCK since time 0 is pat[r].
   initial forever begin @(posedge tck); rise_cnt++; end
   initial forever begin @(negedge tck); tdo = pat[rise_cnt % 256]; end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Expected TCK-by-TCK behaviour of one command, straight from the TAP walk rules.
   function automatic exp_t model(input logic [1:0] op, input int len, input logic [31:0] data,
                                  input bit synced, input int base);
      exp_t e;
      int n = 0;
      int l;
      e.op = op; e.rsp = '0; e.tms_v = '0; e.tdi_v = '0; e.acc = 0; e.trst_low = 0;
      if (!synced || op == OP_RESET) begin
         for (int k = 0; k < 6; k++) begin e.tms_v[n] = (k < 5); n++; end
         e.trst_low = TRST_EN_TB ? 4 * CLK_DIV : 0;
      end
      if (op == OP_IR || op == OP_DR) begin
         l = (len < 1) ? 1 : (len > MAX_LEN) ? MAX_LEN : len;
         if (op == OP_IR) begin e.tms_v[n] = 1'b1; e.tms_v[n+1] = 1'b1; n += 4; end
         else begin e.tms_v[n] = 1'b1; n += 3; end
         for (int i = 0; i < l; i++) begin
            e.tms_v[n] = (i == l - 1);
            e.tdi_v[n] = data[i];
            e.rsp[i]   = pat[(base + n) % 256];
            n++;
         end
         e.tms_v[n] = 1'b1;
         n += 2;
      end else if (op == OP_IDLE) begin
         n += len;
      end
      e.ntck = n;
      e.lat  = (n == 0) ? 1 : 2 * CLK_DIV * n;
      return e;
   endfunction

   // Monitor: collect pin activity, compare against the scoreboard on each response.
   initial begin
      logic [63:0] obs_tms, obs_tdi;
      int obs_n, trst_low;
      logic prev_tck;
      exp_t e;
      obs_tms = '0; obs_tdi = '0; obs_n = 0; trst_low = 0; prev_tck = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (!dbg_rst) begin
            obs_tms = '0; obs_tdi = '0; obs_n = 0; trst_low = 0; prev_tck = 1'b0;
         end else begin
            if (tck && !prev_tck) begin
               if (obs_n < 64) begin obs_tms[obs_n] = tms; obs_tdi[obs_n] = tdi; end
               obs_n++;
            end
            if (!trst && !cmd_ready) trst_low++;
            prev_tck = tck;
            if (rsp_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_rsp", 64'(rsp_valid), 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  $display("[TB] rsp op=%0d tck=%0d lat=%0d data=%08h", e.op, obs_n, cyc - e.acc, rsp_data);
                  check("rsp_data",  64'(rsp_data), 64'(e.rsp));
                  check("tck_count", 64'(obs_n), 64'(e.ntck));
                  check("tms_seq",   obs_tms, e.tms_v);
                  check("tdi_seq",   obs_tdi, e.tdi_v);
                  check("latency",   64'(cyc - e.acc), 64'(e.lat));
                  check("trst_low",  64'(trst_low), 64'(e.trst_low));
               end
               obs_tms = '0; obs_tdi = '0; obs_n = 0; trst_low = 0;
            end
         end
      end
   end

   task automatic check_reset_pins();
      check("rst_ready",     64'(cmd_ready), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_data",  64'(rsp_data),  64'd0);
      check("rst_tck",       64'(tck),       64'd0);
      check("rst_tms",       64'(tms),       64'd1);
      check("rst_tdi",       64'(tdi),       64'd0);
      check("rst_trst",      64'(trst),      64'(!TRST_EN_TB));
   endtask

   task automatic do_reset();
      @(posedge sys_clk);
      #2 dbg_rst = 1'b0;
      #1 check_reset_pins();
      repeat (2) @(posedge sys_clk);
      #2 dbg_rst = 1'b1;
      model_synced = 1'b0;
   endtask

   task automatic wait_idle();
      int guard = 0;
      do begin
         @(posedge sys_clk); #1;
         guard++;
      end while ((exp_q.size() != 0 || !cmd_ready) && guard < 2000);
      if (exp_q.size() != 0 || !cmd_ready) begin
         check("idle_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
   endtask

   task automatic issue(input logic [1:0] op, input int len, input logic [31:0] data, input bit abort);
      exp_t e;
      int guard = 0;
      @(negedge sys_clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_len = LEN_W'(len); cmd_data = data;
      while (!cmd_ready && guard < 2000) begin @(negedge sys_clk); guard++; end
      if (!cmd_ready) begin
         check("ready_timeout", 64'(cmd_ready), 64'd1);
         cmd_valid = 1'b0;
         return;
      end
      e = model(op, len, data, model_synced, rise_cnt);
      e.acc = cyc + 1;
      if (!abort) exp_q.push_back(e);
      @(posedge sys_clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op = 2'($urandom); cmd_len = LEN_W'($urandom); cmd_data = $urandom;
      check("ready_drop", 64'(cmd_ready), 64'd0);
      model_synced = 1'b1;
      if (abort) begin
         repeat (40) @(posedge sys_clk);
         do_reset();
      end
   endtask

   initial begin
      logic [7:0] tgt;
      int b;
      int op_i, len_i;
      cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_data = '0; dbg_rst = 1'b0;
      for (int i = 0; i < 256; i++) pat[i] = 1'($urandom);
      tdo = pat[0];
      repeat (3) @(posedge sys_clk);
      #1 check_reset_pins();
      @(posedge sys_clk);
      #2 dbg_rst = 1'b1;

      issue(OP_RESET, 0, 32'h0, 1'b0);
      wait_idle();
      // Target answers 8'h3C during the 8 shift TCKs (positions 3..10 of a synced SHIFT_DR).
      tgt = 8'h3C;
      b = rise_cnt;
      for (int i = 0; i < 8; i++) pat[(b + 3 + i) % 256] = tgt[i];
      issue(OP_DR, 8, 32'hA5, 1'b0);
      wait_idle();
      do_reset();
      issue(OP_IR, 4, 32'hA, 1'b0);
      issue(OP_IDLE, 0, 32'h0, 1'b0);
      issue(OP_IDLE, 3, 32'h0, 1'b0);
      issue(OP_DR, 0, 32'h1, 1'b0);
      issue(OP_IR, MAX_LEN + 3, $urandom, 1'b0);
      wait_idle();
      issue(OP_DR, 20, $urandom, 1'b1);
      issue(OP_DR, 5, $urandom, 1'b0);

      for (int t = 0; t < 40; t++) begin
         op_i  = $urandom_range(0, 3);
         len_i = (op_i == 3) ? $urandom_range(0, 20) : $urandom_range(0, MAX_LEN + 3);
         issue(2'(op_i), len_i, $urandom, 1'b0);
         if (t % 13 == 12) begin
            wait_idle();
            do_reset();
         end
      end
      wait_idle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
